ahb_lite_sram_slave: RTL
========================

# ahb_lite_sram_slave

AHB-Lite slave that sits directly downstream of the `ahb_if` bus and terminates transfers into an on-chip byte-addressable SRAM. It decodes address/control, inserts configurable wait states, and commits writes with byte-lane enables. It returns read data and generates the two-cycle ERROR response for illegal transfers. It is the DUT-side counterpart the AHB master VIP drives in block-level benches.

## Interface
- ADDR_WIDTH, 32, width of haddr.
- DATA_WIDTH, 32, width of hwdata/hrdata. Only 32 is legal; any other value is an elaboration error.
- MEM_BYTES, 4096, SRAM size in bytes. Must be a power of two and ≥ 4.
- WAIT_STATES, 0, extra data-phase cycles with hreadyout=0 before OKAY completion. Legal range is 0..7.

Ports:
- hclk  in  1  bus clock; all state on rising edge.
- hresetn  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  byte address.
- htrans  in  2  IDLE/BUSY/NONSEQ/SEQ.
- hwrite  in  1  1 = write.
- hsize  in  3  transfer size.
- hburst  in  3  burst type; ignored, because every beat is decoded independently.
- hprot  in  4  protection; ignored.
- hwdata  in  DATA_WIDTH  write data, valid in the data phase.
- hready  in  1  bus-level HREADY from the mux.
- hreadyout  out  1  this slave's ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  DATA_WIDTH  read data.

## Operation
- **Transfer acceptance.** A transfer is accepted on a rising edge where hsel=1, hready=1 and htrans[1]=1 (NONSEQ or SEQ).
  - On acceptance, capture haddr, hwrite and hsize.
  - IDLE and BUSY transfers, and transfers with hsel=0, are not accepted. They always get a zero-wait OKAY.
- **Error check.** An accepted transfer is illegal if any of the following holds:
  - haddr ≥ MEM_BYTES;
  - hsize > WORD;
  - it is misaligned: HALFWORD with haddr[0]=1, or WORD with haddr[1:0]≠0.
- **FSM states:** IDLE, WAIT, ERR1, ERR2.
  - IDLE → WAIT on an accepted legal transfer when WAIT_STATES>0. With WAIT_STATES=0, a legal transfer completes in the first data-phase cycle and the FSM stays IDLE/OKAY.
  - WAIT: the wait counter loads WAIT_STATES−1 and decrements each cycle with hreadyout=0. When the counter is 0, the next cycle is the completion cycle: hreadyout=1, hresp=0, and the FSM returns to IDLE.
  - IDLE → ERR1 on an accepted illegal transfer.
  - ERR1 drives hreadyout=0, hresp=1, then goes to ERR2.
  - ERR2 drives hreadyout=1, hresp=1, then goes to IDLE. An illegal transfer never modifies memory, regardless of WAIT_STATES.
- **Writes.**
  - A write is committed at the edge that ends its completion cycle, using hwdata sampled on that edge.
  - Lanes are little-endian:
    - BYTE writes lane haddr[1:0].
    - HALFWORD writes lanes {2·haddr[1]+1, 2·haddr[1]}.
    - WORD writes all four lanes.
  - Unselected lanes are preserved.
- **Reads.**
  - hrdata = full word at captured haddr[log2(MEM_BYTES)-1:2] during the completion cycle. It is 0 in every other cycle.
  - No lane masking is applied; the master extracts the bytes it needs.
- **Pipelining.**
  - A new transfer may be accepted in the completion cycle (or in ERR2) of the previous one.
  - A read immediately following a write to the same word returns the newly written data, because the write commits before the read's data phase.
- **Memory contents** are not reset.

## Timing
- **Reset values:** hreadyout=1, hresp=0, hrdata=0, FSM=IDLE, wait counter=0.
- **Latency:**
  - An OKAY transfer completes WAIT_STATES+1 cycles after its address phase.
  - An ERROR transfer always completes in 2 data-phase cycles.
- **Reset mid-operation:** asserting hresetn=0 in any state immediately forces the reset values.
  - A pending write is discarded and memory is not written.
  - The captured control is cleared.
- **hready=0 from another slave:** address and control are not captured. The FSM holds IDLE and hreadyout stays 1.
- **Outputs** hreadyout, hresp and hrdata are registered or decoded from registered state only. There is no combinational path from the inputs to these outputs.

## Structure
- Package `ahb_pkg` holds `htrans_t`, `hsize_t`, `hburst_t`, `hresp_t`, the FSM state enum `ahb_slv_state_t`, and the byte-lane decode function `ahb_byte_strobe(addr[1:0], hsize) → logic[3:0]`.
- Sub-module `ahb_sram_bank` provides the byte-enable memory: write port (we, addr, strb, wdata) and asynchronous read port. It is MEM_BYTES/4 words deep.
- The top level contains the address-phase capture, error decode, wait counter and FSM.

## Test plan
- **Zero-wait write/read (WAIT_STATES=0):** WORD write 0xDEADBEEF to 0x010, then read 0x010 → each data phase has hreadyout=1 and hresp=0; the read returns 0xDEADBEEF.
- **Byte/halfword lanes:** write WORD 0x00000000 to 0x020, BYTE 0xAA to 0x022, HALFWORD 0x5555 to 0x020; then read 0x020 → 0x00AA5555.
- **Wait states (WAIT_STATES=3):** write to 0x004 → hreadyout low for exactly 3 cycles, then high with OKAY; a back-to-back read of 0x004 returns the written data after 3 waits.
- **Errors:** read 0x1000 (MEM_BYTES=4096), then WORD write to 0x002 → each response is exactly hreadyout=0/hresp=1, then hreadyout=1/hresp=1; a later read of 0x000 shows memory unchanged.
- **IDLE/BUSY and unselected:** htrans=BUSY, or hsel=0 with NONSEQ → no capture, hreadyout=1, hresp=0, memory unchanged.
- **Reset in WAIT:** WAIT_STATES=5 write to 0x008; drop hresetn during the 2nd wait cycle → outputs return to reset values immediately; after release, reading 0x008 shows the old contents.

Source files
------------

// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_pkg
//  Description : Shared AHB-Lite types for the SRAM slave: transfer type,
//                transfer size, burst type, response, the slave FSM state
//                encoding and the little-endian byte-lane decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE   = 3'd0,
        HSIZE_HALF   = 3'd1,
        HSIZE_WORD   = 3'd2,
        HSIZE_DWORD  = 3'd3,
        HSIZE_4WORD  = 3'd4,
        HSIZE_8WORD  = 3'd5,
        HSIZE_16WORD = 3'd6,
        HSIZE_32WORD = 3'd7
    } hsize_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_t;

    // IDLE doubles as the OKAY completion cycle when a data phase is pending.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } ahb_slv_state_t;

    // Little-endian lane enables for a 32-bit data bus. Sizes wider than a
    // word never reach the memory, so they decode to no lanes at all.
    function automatic logic [3:0] ahb_byte_strobe(input logic [1:0] addr,
                                                   input hsize_t     size);
        logic [3:0] strb;
        strb = 4'b0000;
        case (size)
            HSIZE_BYTE: strb = 4'b0001 << addr;
            HSIZE_HALF: strb = addr[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: strb = 4'b1111;
            default:    strb = 4'b0000;
        endcase
        return strb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_sram_bank.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_sram_bank
//  Description : Word-organised SRAM with per-byte write enables and an
//                asynchronous read port. Contents are never reset.
//  Ports       : clk_i    - write clock
//                we_i     - write enable (qualified per lane by strb_i)
//                addr_i   - word index, shared by read and write
//                strb_i   - byte-lane write enables, bit n = bits 8n+7:8n
//                wdata_i  - write data
//                rdata_o  - word at addr_i (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_sram_bank
    import ahb_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [3:0]    strb_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (strb_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule
`default_nettype wire

// File: rtl/ahb_lite_sram_slave.sv
`default_nettype none
// ============================================================================
//  Module      : ahb_lite_sram_slave
//  Description : AHB-Lite slave terminating transfers into an on-chip SRAM.
//                Captures the address phase, flags illegal transfers
//                (out of range, too wide, misaligned) with a two-cycle ERROR,
//                inserts WAIT_STATES wait cycles before OKAY completion and
//                commits byte-lane writes at the end of the completion cycle.
//  Ports       : hclk/hresetn         - clock, async active-low reset
//                hsel/haddr/htrans    - address phase select, address, type
//                hwrite/hsize         - direction and transfer size
//                hburst/hprot         - accepted but not used
//                hwdata               - write data (data phase)
//                hready               - bus-level ready from the mux
//                hreadyout/hresp      - this slave's ready and response
//                hrdata               - read data, zero outside completion
//  Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_sram_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_BYTES   = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  hsel,
    input  logic [ADDR_WIDTH-1:0] haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [2:0]            hburst,
    input  logic [3:0]            hprot,
    input  logic [DATA_WIDTH-1:0] hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [DATA_WIDTH-1:0] hrdata
);

    localparam int         c_BYTE_AW   = $clog2(MEM_BYTES);
    localparam int         c_WIDX_W    = (c_BYTE_AW > 2) ? c_BYTE_AW - 2 : 1;
    localparam int         c_DEPTH     = MEM_BYTES / 4;
    localparam logic [2:0] c_WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    // ------------------------------------------------------------------
    // Parameter legality
    // ------------------------------------------------------------------
    generate
        if (DATA_WIDTH != 32) begin : g_bad_data_width
            $error("ahb_lite_sram_slave: DATA_WIDTH must be 32");
        end
        if ((MEM_BYTES < 4) || ((MEM_BYTES & (MEM_BYTES - 1)) != 0)) begin : g_bad_mem_bytes
            $error("ahb_lite_sram_slave: MEM_BYTES must be a power of two >= 4");
        end
        if ((WAIT_STATES < 0) || (WAIT_STATES > 7)) begin : g_bad_wait_states
            $error("ahb_lite_sram_slave: WAIT_STATES must be 0..7");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    ahb_slv_state_t        r_state_q, w_state_d;
    logic [2:0]            r_cnt_q,   w_cnt_d;
    logic                  r_pend_q,  w_pend_d;   // legal data phase outstanding
    logic                  r_write_q;
    hsize_t                r_size_q;
    logic [1:0]            r_lane_q;
    logic [c_WIDX_W-1:0]   r_widx_q;

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_addr_oor;
    logic                  w_bad_size;
    logic                  w_misalign;
    logic                  w_illegal;
    logic                  w_complete;
    logic                  w_we;
    logic [3:0]            w_strb;
    logic [31:0]           w_rdata;
    logic                  w_unused_ok;

    assign w_unused_ok = ^{hburst, hprot, htrans[0]};

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    // Only WAIT and ERR1 stall the bus; every other state can take a new
    // address phase, which is what lets transfers overlap the completion
    // cycle and ERR2.
    assign w_ready    = (r_state_q != ST_WAIT) && (r_state_q != ST_ERR1);
    assign w_accept   = hsel && hready && htrans[1] && w_ready;

    assign w_addr_oor = (haddr >= ADDR_WIDTH'(MEM_BYTES));
    assign w_bad_size = (hsize_t'(hsize) > HSIZE_WORD);
    assign w_misalign = ((hsize == HSIZE_HALF) && haddr[0]) ||
                        ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
    assign w_illegal  = w_addr_oor || w_bad_size || w_misalign;

    // ------------------------------------------------------------------
    // FSM and wait counter
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_pend_d  = r_pend_q;
        case (r_state_q)
            ST_WAIT: begin
                if (r_cnt_q == 3'd0) begin
                    w_state_d = ST_IDLE;        // next cycle completes
                end else begin
                    w_cnt_d = r_cnt_q - 3'd1;
                end
            end
            ST_ERR1: begin
                w_state_d = ST_ERR2;
            end
            default: begin                      // ST_IDLE, ST_ERR2
                w_state_d = ST_IDLE;
                w_pend_d  = 1'b0;
                if (w_accept) begin
                    if (w_illegal) begin
                        w_state_d = ST_ERR1;
                    end else begin
                        w_pend_d = 1'b1;
                        if (WAIT_STATES > 0) begin
                            w_state_d = ST_WAIT;
                            w_cnt_d   = c_WAIT_LOAD;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_state_q <= ST_IDLE;
            r_cnt_q   <= 3'd0;
            r_pend_q  <= 1'b0;
            r_write_q <= 1'b0;
            r_size_q  <= HSIZE_BYTE;
            r_lane_q  <= 2'b00;
            r_widx_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_pend_q  <= w_pend_d;
            if (w_accept) begin
                r_write_q <= hwrite;
                r_size_q  <= hsize_t'(hsize);
                r_lane_q  <= haddr[1:0];
                r_widx_q  <= haddr[c_WIDX_W+1:2];
            end
        end
    end

    // ------------------------------------------------------------------
    // Data phase
    // ------------------------------------------------------------------
    // A pending legal transfer sitting in IDLE is in its completion cycle.
    assign w_complete = r_pend_q && (r_state_q == ST_IDLE);
    assign w_we       = w_complete && r_write_q;
    assign w_strb     = ahb_byte_strobe(r_lane_q, r_size_q);

    ahb_sram_bank #(
        .DEPTH (c_DEPTH),
        .AW    (c_WIDX_W)
    ) u_bank (
        .clk_i   (hclk),
        .we_i    (w_we),
        .addr_i  (r_widx_q),
        .strb_i  (w_strb),
        .wdata_i (hwdata),
        .rdata_o (w_rdata)
    );

    assign hreadyout = w_ready;
    assign hresp     = (r_state_q == ST_ERR1) || (r_state_q == ST_ERR2);
    assign hrdata    = (w_complete && !r_write_q) ? w_rdata : '0;

endmodule
`default_nettype wire
